// File: rtl/ctrl_pkg.sv
// ctrl_pkg: shared types and constants for the accumulator-machine control unit.
//   state_e     sequencer states (4-bit encoding)
//   op_class_e  instruction classes produced by ctrl_decoder
//   OP_*        ISA opcodes held in IR[15:12]
//   ALU_*       ALU opcodes (operand1 = ACC, operand2 = MBR)
//   SEL_*       datapath mux select values
package ctrl_pkg;

  typedef enum logic [3:0] {
    S_IDLE,
    S_FETCH_ADDR,
    S_FETCH_READ,
    S_FETCH_MBR,
    S_FETCH_IR,
    S_DECODE,
    S_OP_ADDR,
    S_OP_READ,
    S_OP_MBR,
    S_EXEC,
    S_STORE_SETUP,
    S_STORE_WR,
    S_HALTED
  } state_e;

  typedef enum logic [2:0] {
    CLS_MEM_ALU,
    CLS_LOAD,
    CLS_STORE,
    CLS_SHIFT,
    CLS_BRANCH,
    CLS_HALT,
    CLS_NOP
  } op_class_e;

  localparam logic [3:0] OP_HALT  = 4'h0;
  localparam logic [3:0] OP_LOAD  = 4'h1;
  localparam logic [3:0] OP_STORE = 4'h2;
  localparam logic [3:0] OP_ADD   = 4'h3;
  localparam logic [3:0] OP_SUB   = 4'h4;
  localparam logic [3:0] OP_AND   = 4'h5;
  localparam logic [3:0] OP_OR    = 4'h6;
  localparam logic [3:0] OP_XOR   = 4'h7;
  localparam logic [3:0] OP_SHL   = 4'h8;
  localparam logic [3:0] OP_SHR   = 4'h9;
  localparam logic [3:0] OP_JMP   = 4'hA;
  localparam logic [3:0] OP_JZ    = 4'hB;
  localparam logic [3:0] OP_JNEG  = 4'hC;
  localparam logic [3:0] OP_CMPGT = 4'hD;
  localparam logic [3:0] OP_CMPEQ = 4'hE;
  localparam logic [3:0] OP_NOP   = 4'hF;

  localparam logic [3:0] ALU_ADD   = 4'b0000;
  localparam logic [3:0] ALU_SUB   = 4'b0001;
  localparam logic [3:0] ALU_SHL   = 4'b0100;
  localparam logic [3:0] ALU_SHR   = 4'b0101;
  localparam logic [3:0] ALU_AND   = 4'b1000;
  localparam logic [3:0] ALU_OR    = 4'b1001;
  localparam logic [3:0] ALU_XOR   = 4'b1010;
  localparam logic [3:0] ALU_CMPGT = 4'b1110;
  localparam logic [3:0] ALU_CMPEQ = 4'b1111;

  // MAR and PC share the same select meaning: 0 = PC side, 1 = IR operand
  localparam logic SEL_PC  = 1'b0;
  localparam logic SEL_IR  = 1'b1;
  localparam logic SEL_MEM = 1'b0;
  localparam logic SEL_ACC = 1'b1;
  localparam logic SEL_ALU = 1'b0;
  localparam logic SEL_MBR = 1'b1;

endpackage

// File: rtl/ctrl_decoder.sv
// ctrl_decoder: combinational opcode decoder.
//   opcode    in   IR[15:12]
//   op_class  out  instruction class (op_class_e encoding)
//   alu_op    out  ALU opcode for ALU-using instructions, ALU_ADD otherwise
module ctrl_decoder
  import ctrl_pkg::*;
(
  input  logic [3:0] opcode,
  output logic [2:0] op_class,
  output logic [3:0] alu_op
);

  always_comb begin
    op_class = CLS_NOP;
    alu_op   = ALU_ADD;
    case (opcode)
      OP_HALT:  op_class = CLS_HALT;
      OP_LOAD:  op_class = CLS_LOAD;
      OP_STORE: op_class = CLS_STORE;
      OP_ADD:   begin op_class = CLS_MEM_ALU; alu_op = ALU_ADD;   end
      OP_SUB:   begin op_class = CLS_MEM_ALU; alu_op = ALU_SUB;   end
      OP_AND:   begin op_class = CLS_MEM_ALU; alu_op = ALU_AND;   end
      OP_OR:    begin op_class = CLS_MEM_ALU; alu_op = ALU_OR;    end
      OP_XOR:   begin op_class = CLS_MEM_ALU; alu_op = ALU_XOR;   end
      OP_CMPGT: begin op_class = CLS_MEM_ALU; alu_op = ALU_CMPGT; end
      OP_CMPEQ: begin op_class = CLS_MEM_ALU; alu_op = ALU_CMPEQ; end
      OP_SHL:   begin op_class = CLS_SHIFT;   alu_op = ALU_SHL;   end
      OP_SHR:   begin op_class = CLS_SHIFT;   alu_op = ALU_SHR;   end
      OP_JMP, OP_JZ, OP_JNEG: op_class = CLS_BRANCH;
      default:  op_class = CLS_NOP;
    endcase
  end

endmodule

// File: rtl/control_sequencer.sv
// control_sequencer: multi-cycle fetch/decode/execute control unit for the
// 16-bit accumulator machine.
//   clk, reset_n         clock; synchronous active-low reset
//   start                leave IDLE and begin fetching
//   ir_in, acc_in        current IR / ACC contents
//   mar_write/mar_sel    MAR load, source (PC / IR operand)
//   mbr_write/mbr_sel    MBR load, source (memory / ACC)
//   ir_write             IR load from MBR
//   pc_write/pc_sel      PC load, source (PC+1 / IR operand)
//   acc_write/acc_sel    ACC load, source (ALU / MBR)
//   alu_op               ALU opcode, non-zero only in EXEC
//   mem_we               memory write (addr = MAR, data = MBR)
//   busy, halted         status
//   fetch_count          instructions fetched, wrapping
module control_sequencer
  import ctrl_pkg::*;
#(
  parameter int OPND_BITS   = 12,
  parameter int COUNT_WIDTH = 16
) (
  input  logic                   clk,
  input  logic                   reset_n,
  input  logic                   start,
  input  logic [15:0]            ir_in,
  input  logic [15:0]            acc_in,
  output logic                   mar_write,
  output logic                   mar_sel,
  output logic                   mbr_write,
  output logic                   mbr_sel,
  output logic                   ir_write,
  output logic                   pc_write,
  output logic                   pc_sel,
  output logic                   acc_write,
  output logic                   acc_sel,
  output logic [3:0]             alu_op,
  output logic                   mem_we,
  output logic                   busy,
  output logic                   halted,
  output logic [COUNT_WIDTH-1:0] fetch_count
);

  state_e                 state_q, state_d;
  logic [COUNT_WIDTH-1:0] fetch_count_q, fetch_count_d;
  logic [3:0]             opcode;
  logic [2:0]             op_class_raw;
  op_class_e              op_class;
  logic [3:0]             dec_alu_op;
  logic                   branch_taken;
  logic                   unused_operand;

  assign opcode = ir_in[OPND_BITS +: 4];
  // Operand field is routed to MAR/PC by the datapath muxes, not by this block
  assign unused_operand = ^ir_in[OPND_BITS-1:0];

  ctrl_decoder u_decoder (
    .opcode   (opcode),
    .op_class (op_class_raw),
    .alu_op   (dec_alu_op)
  );

  assign op_class    = op_class_e'(op_class_raw);
  assign fetch_count = fetch_count_q;

  always_comb begin
    case (opcode)
      OP_JMP:  branch_taken = 1'b1;
      OP_JZ:   branch_taken = (acc_in == '0);
      OP_JNEG: branch_taken = acc_in[15];
      default: branch_taken = 1'b0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q       <= S_IDLE;
      fetch_count_q <= '0;
    end else begin
      state_q       <= state_d;
      fetch_count_q <= fetch_count_d;
    end
  end

  always_comb begin
    state_d       = state_q;
    fetch_count_d = fetch_count_q;
    mar_write     = 1'b0;
    mar_sel       = SEL_PC;
    mbr_write     = 1'b0;
    mbr_sel       = SEL_MEM;
    ir_write      = 1'b0;
    pc_write      = 1'b0;
    pc_sel        = SEL_PC;
    acc_write     = 1'b0;
    acc_sel       = SEL_ALU;
    alu_op        = ALU_ADD;
    mem_we        = 1'b0;
    busy          = (state_q != S_IDLE) && (state_q != S_HALTED);
    halted        = (state_q == S_HALTED);

    case (state_q)
      S_IDLE: if (start) state_d = S_FETCH_ADDR;
      S_FETCH_ADDR: begin
        mar_write = 1'b1;
        mar_sel   = SEL_PC;
        state_d   = S_FETCH_READ;
      end
      S_FETCH_READ: state_d = S_FETCH_MBR;
      S_FETCH_MBR: begin
        mbr_write = 1'b1;
        mbr_sel   = SEL_MEM;
        state_d   = S_FETCH_IR;
      end
      S_FETCH_IR: begin
        ir_write      = 1'b1;
        pc_write      = 1'b1;
        pc_sel        = SEL_PC;
        fetch_count_d = fetch_count_q + COUNT_WIDTH'(1);
        state_d       = S_DECODE;
      end
      S_DECODE: begin
        case (op_class)
          CLS_HALT:              state_d = S_HALTED;
          CLS_MEM_ALU, CLS_LOAD: state_d = S_OP_ADDR;
          CLS_STORE:             state_d = S_STORE_SETUP;
          CLS_SHIFT:             state_d = S_EXEC;
          CLS_BRANCH: begin
            // A not-taken branch leaves both the enable and the select low
            pc_write = branch_taken;
            pc_sel   = branch_taken ? SEL_IR : SEL_PC;
            state_d  = S_FETCH_ADDR;
          end
          default:               state_d = S_FETCH_ADDR;
        endcase
      end
      S_OP_ADDR: begin
        mar_write = 1'b1;
        mar_sel   = SEL_IR;
        state_d   = S_OP_READ;
      end
      S_OP_READ: state_d = S_OP_MBR;
      S_OP_MBR: begin
        mbr_write = 1'b1;
        mbr_sel   = SEL_MEM;
        state_d   = S_EXEC;
      end
      S_EXEC: begin
        acc_write = 1'b1;
        if (op_class == CLS_LOAD) begin
          acc_sel = SEL_MBR;
        end else begin
          acc_sel = SEL_ALU;
          alu_op  = dec_alu_op;
        end
        state_d = S_FETCH_ADDR;
      end
      S_STORE_SETUP: begin
        mar_write = 1'b1;
        mar_sel   = SEL_IR;
        mbr_write = 1'b1;
        mbr_sel   = SEL_ACC;
        state_d   = S_STORE_WR;
      end
      S_STORE_WR: begin
        mem_we  = 1'b1;
        state_d = S_FETCH_ADDR;
      end
      S_HALTED: state_d = S_HALTED;
      default:  state_d = S_IDLE;
    endcase
  end

endmodule

// File: tb/tb_control_sequencer.sv
// Bench for control_sequencer: a plain datapath (registers, ALU, memory) is
// steered by the DUT; an instruction-level model expands each instruction
// into its expected per-cycle output vectors and is compared every cycle.
module tb_control_sequencer;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset_n, start, start2;
  logic        mar_write, mar_sel, mbr_write, mbr_sel, ir_write;
  logic        pc_write, pc_sel, acc_write, acc_sel, mem_we, busy, halted;
  logic [3:0]  alu_op;
  logic [15:0] fetch_count;

  // datapath plant
  logic [15:0] pc_q, acc_q, mar_q, mbr_q, ir_q, dout_q;
  logic [15:0] pmem [0:16383];

  // second instance with a narrow counter for the wrap check
  logic        unused2_mw, unused2_ms, unused2_bw, unused2_bs, unused2_iw;
  logic        unused2_pw, unused2_ps, unused2_aw, unused2_as, unused2_we;
  logic        unused2_busy, unused2_halted;
  logic [3:0]  unused2_alu, fc2;

  control_sequencer #(.OPND_BITS(12), .COUNT_WIDTH(16)) dut (
    .clk(clk), .reset_n(reset_n), .start(start), .ir_in(ir_q), .acc_in(acc_q),
    .mar_write(mar_write), .mar_sel(mar_sel), .mbr_write(mbr_write), .mbr_sel(mbr_sel),
    .ir_write(ir_write), .pc_write(pc_write), .pc_sel(pc_sel), .acc_write(acc_write),
    .acc_sel(acc_sel), .alu_op(alu_op), .mem_we(mem_we), .busy(busy), .halted(halted),
    .fetch_count(fetch_count)
  );

  control_sequencer #(.OPND_BITS(12), .COUNT_WIDTH(4)) dut2 (
    .clk(clk), .reset_n(reset_n), .start(start2), .ir_in(16'hF000), .acc_in(16'h0000),
    .mar_write(unused2_mw), .mar_sel(unused2_ms), .mbr_write(unused2_bw), .mbr_sel(unused2_bs),
    .ir_write(unused2_iw), .pc_write(unused2_pw), .pc_sel(unused2_ps), .acc_write(unused2_aw),
    .acc_sel(unused2_as), .alu_op(unused2_alu), .mem_we(unused2_we), .busy(unused2_busy),
    .halted(unused2_halted), .fetch_count(fc2)
  );

  logic [15:0] dut_v;
  assign dut_v = {mar_write, mar_sel, mbr_write, mbr_sel, ir_write, pc_write, pc_sel,
                  acc_write, acc_sel, alu_op, mem_we, busy, halted};

  function automatic logic [15:0] plant_alu(input logic [3:0] op, input logic [15:0] a, b);
    case (op)
      4'b0000: return a + b;
      4'b0001: return a - b;
      4'b1000: return a & b;
      4'b1001: return a | b;
      4'b1010: return a ^ b;
      4'b0100: return a << 1;
      4'b0101: return a >> 1;
      4'b1110: return (a > b) ? 16'd1 : 16'd0;
      4'b1111: return (a == b) ? 16'd1 : 16'd0;
      default: return 16'hDEAD;
    endcase
  endfunction

  always @(posedge clk) begin
    if (!reset_n) begin
      pc_q <= '0; acc_q <= '0; mar_q <= '0; mbr_q <= '0; ir_q <= '0;
    end else begin
      if (mar_write) mar_q <= mar_sel ? {4'b0, ir_q[11:0]} : pc_q;
      if (mbr_write) mbr_q <= mbr_sel ? acc_q : dout_q;
      if (ir_write)  ir_q  <= mbr_q;
      if (pc_write)  pc_q  <= pc_sel ? {4'b0, ir_q[11:0]} : pc_q + 16'd1;
      if (acc_write) acc_q <= acc_sel ? mbr_q : plant_alu(alu_op, acc_q, mbr_q);
    end
    dout_q <= pmem[mar_q[13:0]];
    if (mem_we) pmem[mar_q[13:0]] <= mbr_q;
  end

  // ---------------- instruction-level reference model ----------------
  localparam int M_IDLE = 0, M_RUN = 1, M_HALT = 2;
  logic [15:0] mmem [0:16383];
  logic [31:0] mq [$];
  int          mmode;
  logic        mvalid = 1'b0;
  logic        hpend;
  logic [15:0] mpc, macc, mcnt;
  int          checks = 0, errors = 0;

  function automatic logic [15:0] ov(input logic mw, ms, bw, bs, iw, pw, ps, aw, asl,
                                     input logic [3:0] op, input logic we, bsy, hlt);
    return {mw, ms, bw, bs, iw, pw, ps, aw, asl, op, we, bsy, hlt};
  endfunction

  function automatic logic [3:0] spec_alu(input logic [3:0] opc);
    case (opc)
      4'h3: return 4'b0000;  4'h4: return 4'b0001;  4'h5: return 4'b1000;
      4'h6: return 4'b1001;  4'h7: return 4'b1010;  4'h8: return 4'b0100;
      4'h9: return 4'b0101;  4'hD: return 4'b1110;  4'hE: return 4'b1111;
      default: return 4'b0000;
    endcase
  endfunction

  function automatic logic [15:0] isa_result(input logic [3:0] opc, input logic [15:0] a, m);
    case (opc)
      4'h1: return m;
      4'h3: return a + m;
      4'h4: return a - m;
      4'h5: return a & m;
      4'h6: return a | m;
      4'h7: return a ^ m;
      4'h8: return {a[14:0], 1'b0};
      4'h9: return {1'b0, a[15:1]};
      4'hD: return (a > m) ? 16'd1 : 16'd0;
      4'hE: return (a == m) ? 16'd1 : 16'd0;
      default: return a;
    endcase
  endfunction

  task automatic push(input logic [15:0] v);
    mq.push_back({v, mcnt});
  endtask

  task automatic expand();
    logic [15:0] ir, a, bz;
    logic [3:0]  opc;
    logic        take;
    bz  = ov(0,0,0,0,0,0,0,0,0,4'h0,0,1,0);
    ir  = mmem[mpc[13:0]];
    mpc = mpc + 16'd1;
    opc = ir[15:12];
    a   = {4'b0, ir[11:0]};
    push(ov(1,0,0,0,0,0,0,0,0,4'h0,0,1,0));
    push(bz);
    push(ov(0,0,1,0,0,0,0,0,0,4'h0,0,1,0));
    push(ov(0,0,0,0,1,1,0,0,0,4'h0,0,1,0));
    mcnt = mcnt + 16'd1;
    case (opc)
      4'h0: begin push(bz); hpend = 1'b1; end
      4'h2: begin
        push(bz);
        push(ov(1,1,1,1,0,0,0,0,0,4'h0,0,1,0));
        push(ov(0,0,0,0,0,0,0,0,0,4'h0,1,1,0));
        mmem[a[13:0]] = macc;
      end
      4'h8, 4'h9: begin
        push(bz);
        push(ov(0,0,0,0,0,0,0,1,0,spec_alu(opc),0,1,0));
        macc = isa_result(opc, macc, 16'h0);
      end
      4'hA, 4'hB, 4'hC: begin
        take = (opc == 4'hA) || (opc == 4'hB && macc == 16'h0) || (opc == 4'hC && macc[15]);
        push(ov(0,0,0,0,0,take,take,0,0,4'h0,0,1,0));
        if (take) mpc = a;
      end
      4'hF: push(bz);
      default: begin
        push(bz);
        push(ov(1,1,0,0,0,0,0,0,0,4'h0,0,1,0));
        push(bz);
        push(ov(0,0,1,0,0,0,0,0,0,4'h0,0,1,0));
        push(ov(0,0,0,0,0,0,0,1,(opc == 4'h1),spec_alu(opc),0,1,0));
        macc = isa_result(opc, macc, mmem[a[13:0]]);
      end
    endcase
  endtask

  always @(posedge clk) begin
    if (!reset_n) begin
      mvalid = 1'b1; mmode = M_IDLE; mq.delete();
      mcnt = '0; mpc = '0; macc = '0; hpend = 1'b0;
    end else if (mvalid) begin
      case (mmode)
        M_IDLE: if (start) begin mmode = M_RUN; expand(); end
        M_RUN: begin
          void'(mq.pop_front());
          if (mq.size() == 0) begin
            if (hpend) mmode = M_HALT;
            else expand();
          end
        end
        default: ;
      endcase
    end
  end

  logic [15:0] ev, ec;
  always @(negedge clk) begin
    if (mvalid) begin
      case (mmode)
        M_RUN:   begin ev = mq[0][31:16]; ec = mq[0][15:0]; end
        M_HALT:  begin ev = ov(0,0,0,0,0,0,0,0,0,4'h0,0,0,1); ec = mcnt; end
        default: begin ev = '0; ec = mcnt; end
      endcase
      checks++;
      if (dut_v !== ev || fetch_count !== ec) begin
        errors++;
        $display("FAIL cycle_outputs t=%0t got v=%h cnt=%h want v=%h cnt=%h",
                 $time, dut_v, fetch_count, ev, ec);
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %0h want %0h", name, act, exp);
    end
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  // ---------------- stimulus ----------------
  initial begin
    logic [15:0] w;
    logic [3:0]  opc;
    int          nmis;
    reset_n = 1'b0; start = 1'b1; start2 = 1'b0;
    for (int i = 0; i < 16384; i++) begin
      w = 16'($urandom);
      mmem[i] = w;
      pmem[i] <= w;
    end
    w = 16'h1010; mmem[16'h00] = w; pmem[16'h00] <= w;
    w = 16'h3011; mmem[16'h01] = w; pmem[16'h01] <= w;
    w = 16'h1012; mmem[16'h02] = w; pmem[16'h02] <= w;
    w = 16'h2020; mmem[16'h03] = w; pmem[16'h03] <= w;
    w = 16'h1013; mmem[16'h04] = w; pmem[16'h04] <= w;
    w = 16'hB040; mmem[16'h05] = w; pmem[16'h05] <= w;
    w = 16'h0005; mmem[16'h10] = w; pmem[16'h10] <= w;
    w = 16'h0007; mmem[16'h11] = w; pmem[16'h11] <= w;
    w = 16'hBEEF; mmem[16'h12] = w; pmem[16'h12] <= w;
    w = 16'h0000; mmem[16'h13] = w; pmem[16'h13] <= w;
    w = 16'h0001; mmem[16'h14] = w; pmem[16'h14] <= w;
    w = 16'h8000; mmem[16'h15] = w; pmem[16'h15] <= w;
    w = 16'h1014; mmem[16'h40] = w; pmem[16'h40] <= w;
    w = 16'hB050; mmem[16'h41] = w; pmem[16'h41] <= w;
    w = 16'h1015; mmem[16'h42] = w; pmem[16'h42] <= w;
    w = 16'hC060; mmem[16'h43] = w; pmem[16'h43] <= w;
    w = 16'h0000; mmem[16'h100] = w; pmem[16'h100] <= w;
    w = 16'h8000; mmem[16'h101] = w; pmem[16'h101] <= w;
    // random forward-only program 0x60..0x9F, HALT at 0xA0
    for (int a = 16'h60; a < 16'hA0; a++) begin
      opc = 4'($urandom_range(1, 15));
      if (opc == 4'hA || opc == 4'hB || opc == 4'hC)
        w = {opc, 12'($urandom_range(a + 1, 16'hA0))};
      else if (opc == 4'h8 || opc == 4'h9 || opc == 4'hF)
        w = {opc, 12'($urandom)};
      else
        w = {opc, 12'(16'h100 + $urandom_range(0, 255))};
      mmem[a] = w; pmem[a] <= w;
    end
    w = 16'h0000; mmem[16'hA0] = w; pmem[16'hA0] <= w;

    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("reset_outputs", {16'h0, dut_v}, 32'h0);
    chk("reset_count", {16'h0, fetch_count}, 32'h0);
    reset_n = 1'b1; start = 1'b1;

    for (int k = 1; k <= 78; k++) begin
      @(negedge clk);
      start = 1'($urandom_range(0, 1));
      case (k)
        1:  chk("first_fetch_mar", {mar_write, mar_sel}, 32'h2);
        18: begin
          chk("add_exec_ctrl", {acc_write, acc_sel, alu_op}, 32'h20);
          chk("add_exec_count", {16'h0, fetch_count}, 32'h2);
        end
        19: chk("acc_after_add", {16'h0, acc_q}, 32'd12);
        34: chk("store_wr", {mem_we, mar_q, mbr_q}, {15'h0, 1'b1, 16'h0020, 16'hBEEF});
        35: begin
          chk("store_we_one_cycle", {31'h0, mem_we}, 32'h0);
          chk("store_mem", {16'h0, pmem[16'h20]}, 32'hBEEF);
        end
        48: chk("jz_taken", {pc_write, pc_sel}, 32'h3);
        50: chk("jz_target_fetch", {16'h0, mar_q}, 32'h40);
        62: chk("jz_not_taken", {pc_write, pc_sel}, 32'h0);
        76: chk("jneg_taken", {pc_write, pc_sel}, 32'h3);
        78: chk("jneg_target_fetch", {16'h0, mar_q}, 32'h60);
        default: ;
      endcase
    end

    for (int n = 0; n < 5000 && !halted; n++) begin
      @(negedge clk);
      start = 1'($urandom_range(0, 1));
    end
    chk("halt_reached", {31'h0, halted}, 32'h1);
    repeat (20) begin
      @(negedge clk);
      start = 1'($urandom_range(0, 1));
    end
    chk("halt_sticky", {halted, busy}, 32'h2);
    chk("final_acc", {16'h0, acc_q}, {16'h0, macc});
    nmis = 0;
    for (int i = 0; i < 16'h400; i++) if (pmem[i] !== mmem[i]) nmis++;
    chk("mem_image", nmis, 0);

    // reset while a STORE is writing
    reset_n = 1'b0; start = 1'b0;
    repeat (2) @(negedge clk);
    reset_n = 1'b1; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (int n = 0; n < 200 && !mem_we; n++) @(negedge clk);
    chk("store_wr_seen", {31'h0, mem_we}, 32'h1);
    reset_n = 1'b0;
    @(negedge clk);
    chk("reset_in_store", {mem_we, busy, halted}, 32'h0);

    // narrow counter wrap: NOPs every 5 cycles
    reset_n = 1'b1; start2 = 1'b1;
    @(negedge clk);
    start2 = 1'b0;
    for (int n = 0; n < 200 && fc2 != 4'hF; n++) @(negedge clk);
    chk("wrap_reach_max", {28'h0, fc2}, 32'hF);
    repeat (4) @(negedge clk);
    chk("wrap_hold_max", {28'h0, fc2}, 32'hF);
    @(negedge clk);
    chk("wrap_to_zero", {28'h0, fc2}, 32'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
